// File: rtl/rc4_ksa_ctrl.sv
// RC4 key-scheduling controller for a 16x4-bit S-box store: fills S[k]=k,
// then permutes S with the key using the store's registered read port and dual write port.
module rc4_ksa_ctrl #(
  parameter int KEY_LEN = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [4*KEY_LEN-1:0] i_key,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_mem_en,
  output logic [3:0]           o_mem_raddr,
  input  logic [3:0]           i_mem_rdata,
  output logic [3:0]           o_mem_waddr1,
  output logic [3:0]           o_mem_wdata1,
  output logic [3:0]           o_mem_waddr2,
  output logic [3:0]           o_mem_wdata2
);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_RD_I, S_LD_I, S_SWAP, S_DONE} state_t;

  localparam logic [3:0] KK_LAST = 4'(KEY_LEN - 1);

  state_t      r_state;
  logic [3:0]  r_i, r_j, r_kk, r_si;
  logic [2:0]  r_k;
  logic [63:0] r_key;

  logic [3:0]  w_knib, w_jn;

  // Key is zero-padded to 16 nibbles so kk can index it without width games.
  assign w_knib = r_key[{r_kk, 2'b00} +: 4];
  assign w_jn   = r_j + i_mem_rdata + w_knib;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_kk    <= '0;
      r_k     <= '0;
      r_si    <= '0;
      r_key   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_key   <= 64'(i_key);
          r_i     <= '0;
          r_j     <= '0;
          r_kk    <= '0;
          r_k     <= '0;
          r_state <= S_INIT;
        end
        S_INIT: begin
          r_k <= r_k + 3'd1;
          if (r_k == 3'd7) r_state <= S_RD_I;
        end
        S_RD_I: r_state <= S_LD_I;
        S_LD_I: begin
          r_si    <= i_mem_rdata;
          r_j     <= w_jn;
          r_state <= S_SWAP;
        end
        S_SWAP: begin
          r_i     <= r_i + 4'd1;
          r_kk    <= (r_kk == KK_LAST) ? 4'd0 : r_kk + 4'd1;
          r_state <= (r_i == 4'd15) ? S_DONE : S_RD_I;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The store writes whenever en=0, so en defaults high and only INIT/SWAP drop it.
  always_comb begin
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_mem_en     = 1'b1;
    o_mem_raddr  = '0;
    o_mem_waddr1 = '0;
    o_mem_wdata1 = '0;
    o_mem_waddr2 = '0;
    o_mem_wdata2 = '0;
    case (r_state)
      S_INIT: begin
        o_busy       = 1'b1;
        o_mem_en     = 1'b0;
        o_mem_waddr1 = {r_k, 1'b0};
        o_mem_wdata1 = {r_k, 1'b0};
        o_mem_waddr2 = {r_k, 1'b1};
        o_mem_wdata2 = {r_k, 1'b1};
      end
      S_RD_I: begin
        o_busy      = 1'b1;
        o_mem_raddr = r_i;
      end
      S_LD_I: begin
        o_busy      = 1'b1;
        o_mem_raddr = w_jn;
      end
      S_SWAP: begin
        o_busy       = 1'b1;
        o_mem_en     = 1'b0;
        o_mem_waddr1 = r_i;
        o_mem_wdata1 = i_mem_rdata;
        o_mem_waddr2 = r_j;
        o_mem_wdata2 = r_si;
      end
      S_DONE:  o_done = 1'b1;
      default: ;
    endcase
  end

endmodule
